list_unit: RTL and testbench

LIST_UNIT -- requirements
Module: list_unit

---
 rtl/list_unit_if.sv | 58 +++++
 rtl/list_unit.sv | 82 ++++++++
 tb/tb_list_unit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/list_unit_if.sv
// Handshake bundle between the intersection stage, the closest-hit list unit and the shader stage.
// The item/result records are declared here so every user of the bundle shares one definition.
interface list_unit_if;
    typedef logic [31:0] float_t;
    typedef logic [15:0] triID_t;

    typedef struct packed {
        logic [31:0] u;
        logic [31:0] v;
    } bari_uv_t;

    typedef struct packed {
        logic [7:0] rayID;
        logic [7:0] tag;
    } ray_info_t;

    typedef struct packed {
        ray_info_t ray_info;
        triID_t    triID;
        logic      hit;
        logic      is_last;
        float_t    t_int;
        bari_uv_t  uv;
    } int_to_list_t;

    typedef struct packed {
        ray_info_t ray_info;
        triID_t    triID;
        logic      hit;
        float_t    t_int;
        bari_uv_t  uv;
    } list_to_ss_t;

    logic         int_to_list_valid;
    int_to_list_t int_to_list_data;
    logic         int_to_list_stall;
    logic         list_to_ss_valid;
    list_to_ss_t  list_to_ss_data;
    logic         list_to_ss_stall;

    modport master (
        output int_to_list_valid,
        output int_to_list_data,
        input  int_to_list_stall,
        input  list_to_ss_valid,
        input  list_to_ss_data,
        output list_to_ss_stall
    );

    modport slave (
        input  int_to_list_valid,
        input  int_to_list_data,
        output int_to_list_stall,
        output list_to_ss_valid,
        output list_to_ss_data,
        input  list_to_ss_stall
    );
endinterface

// File: rtl/list_unit.sv
// Closest-hit tracker: keeps the nearest hit per ray slot and emits one result per ray
// when the ray's last intersection item is accepted.
module list_unit #(
    parameter int NUM_RAYS = 64,
    parameter int RAYID_W  = 6
) (
    input logic        clk,
    input logic        rst,
    list_unit_if.slave bus
);
    logic [NUM_RAYS-1:0] bvalid;
    logic [31:0]         best_t   [NUM_RAYS];
    logic [15:0]         best_tri [NUM_RAYS];
    logic [63:0]         best_uv  [NUM_RAYS];

    logic                out_valid;
    logic [15:0]         out_ray_info;
    logic [15:0]         out_tri;
    logic                out_hit;
    logic [31:0]         out_t;
    logic [63:0]         out_uv;

    logic [RAYID_W-1:0]  slot;
    logic                acc;
    logic                cand;
    logic                is_last;

    assign slot    = bus.int_to_list_data.ray_info.rayID[RAYID_W-1:0];
    assign is_last = bus.int_to_list_data.is_last;

    assign bus.int_to_list_stall = bus.int_to_list_valid & out_valid & bus.list_to_ss_stall;
    assign acc = bus.int_to_list_valid & ~bus.int_to_list_stall;

    // t_int is always positive, so the float bit patterns order the same as the values.
    // Strict less-than keeps the earlier entry on a tie.
    assign cand = bus.int_to_list_data.hit &
                  (~bvalid[slot] | (bus.int_to_list_data.t_int < best_t[slot]));

    always_ff @(posedge clk) begin
        if (rst) begin
            bvalid <= '0;
        end else if (acc) begin
            if (is_last) begin
                bvalid[slot] <= 1'b0;
            end else if (cand) begin
                bvalid[slot] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && acc && !is_last && cand) begin
            best_t[slot]   <= bus.int_to_list_data.t_int;
            best_tri[slot] <= bus.int_to_list_data.triID;
            best_uv[slot]  <= bus.int_to_list_data.uv;
        end
    end

    // A consume and a new last-item accept on the same edge simply reload the register.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (acc && is_last) begin
            out_valid <= 1'b1;
        end else if (out_valid && !bus.list_to_ss_stall) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && acc && is_last) begin
            out_ray_info <= bus.int_to_list_data.ray_info;
            out_hit      <= cand | bvalid[slot];
            out_t        <= cand ? bus.int_to_list_data.t_int : best_t[slot];
            out_tri      <= cand ? bus.int_to_list_data.triID : best_tri[slot];
            out_uv       <= cand ? bus.int_to_list_data.uv    : best_uv[slot];
        end
    end

    assign bus.list_to_ss_valid = out_valid;
    assign bus.list_to_ss_data  = {out_ray_info, out_tri, out_hit, out_t, out_uv};
endmodule

// File: tb/tb_list_unit.sv
// Bench for list_unit: table of rays with expected closest hits, scoreboard-checked results,
// plus reset, backpressure and reset-mid-ray sequences.
module tb_list_unit;
    localparam logic [31:0] F1 = 32'h3F80_0000;
    localparam logic [31:0] F2 = 32'h4000_0000;
    localparam logic [31:0] F3 = 32'h4040_0000;
    localparam logic [31:0] F4 = 32'h4080_0000;
    localparam logic [31:0] F5 = 32'h40A0_0000;
    localparam logic [31:0] F6 = 32'h40C0_0000;
    localparam logic [31:0] F7 = 32'h40E0_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    list_unit_if bus ();
    list_unit dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] ray_info;
        logic        hit;
        logic [31:0] t;
        logic [15:0] tri_id;
    } sb_t;
    sb_t sb[$];
    sb_t mon_e;

    typedef struct {
        logic [7:0]  ray;
        logic [15:0] tri_id;
        logic        hit;
        logic        last;
        logic [31:0] t;
        logic        exp_hit;
        logic [31:0] exp_t;
        logic [15:0] exp_tri;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive_item(input logic [7:0] ray, input logic [7:0] tag, input logic [15:0] tid,
                              input logic hit, input logic last, input logic [31:0] t);
        bus.int_to_list_data.ray_info.rayID = ray;
        bus.int_to_list_data.ray_info.tag   = tag;
        bus.int_to_list_data.triID          = tid;
        bus.int_to_list_data.hit            = hit;
        bus.int_to_list_data.is_last        = last;
        bus.int_to_list_data.t_int          = t;
        bus.int_to_list_data.uv.u           = t;
        bus.int_to_list_data.uv.v           = {16'h0, tid};
    endtask

    // Presents one item, waits for acceptance, and queues the expected result for last items.
    task automatic send(input logic [7:0] ray, input logic [7:0] tag, input logic [15:0] tid,
                        input logic hit, input logic last, input logic [31:0] t,
                        input logic eh, input logic [31:0] et, input logic [15:0] etri);
        sb_t e;
        int n;
        n = 0;
        drive_item(ray, tag, tid, hit, last, t);
        bus.int_to_list_valid = 1'b1;
        @(negedge clk);
        while (bus.int_to_list_stall !== 1'b0) begin
            n++;
            if (n > 50) begin
                chk("accept_timeout", 64'(n), 64'd0);
                break;
            end
            @(negedge clk);
        end
        if (last) begin
            e.ray_info = {ray, tag};
            e.hit      = eh;
            e.t        = et;
            e.tri_id   = etri;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.int_to_list_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && bus.list_to_ss_valid === 1'b1 && bus.list_to_ss_stall === 1'b0) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("res_ray_info", 64'(bus.list_to_ss_data.ray_info), 64'(mon_e.ray_info));
                chk("res_hit", 64'(bus.list_to_ss_data.hit), 64'(mon_e.hit));
                if (mon_e.hit) begin
                    chk("res_t", 64'(bus.list_to_ss_data.t_int), 64'(mon_e.t));
                    chk("res_tri", 64'(bus.list_to_ss_data.triID), 64'(mon_e.tri_id));
                    chk("res_uv", bus.list_to_ss_data.uv, {mon_e.t, 16'h0, mon_e.tri_id});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // ray, tri, hit, last, t, exp_hit, exp_t, exp_tri
        vecs.push_back('{8'd3,  16'd10,  1'b1, 1'b0, F5, 1'b0, 32'h0, 16'h0});
        vecs.push_back('{8'd3,  16'd11,  1'b1, 1'b0, F2, 1'b0, 32'h0, 16'h0});
        vecs.push_back('{8'd3,  16'd12,  1'b1, 1'b1, F7, 1'b1, F2,    16'd11});
        vecs.push_back('{8'd0,  16'd1,   1'b0, 1'b1, F1, 1'b0, 32'h0, 16'h0});
        vecs.push_back('{8'd0,  16'd2,   1'b0, 1'b1, F1, 1'b0, 32'h0, 16'h0});
        vecs.push_back('{8'd5,  16'd20,  1'b1, 1'b0, F4, 1'b0, 32'h0, 16'h0});
        vecs.push_back('{8'd5,  16'd21,  1'b1, 1'b1, F4, 1'b1, F4,    16'd20});
        vecs.push_back('{8'd1,  16'd50,  1'b1, 1'b0, F3, 1'b0, 32'h0, 16'h0});
        vecs.push_back('{8'd2,  16'd60,  1'b1, 1'b0, F3, 1'b0, 32'h0, 16'h0});
        vecs.push_back('{8'd1,  16'd51,  1'b1, 1'b0, F2, 1'b0, 32'h0, 16'h0});
        vecs.push_back('{8'd2,  16'd61,  1'b1, 1'b0, F2, 1'b0, 32'h0, 16'h0});
        vecs.push_back('{8'd1,  16'd52,  1'b1, 1'b1, F5, 1'b1, F2,    16'd51});
        vecs.push_back('{8'd2,  16'd62,  1'b1, 1'b1, F5, 1'b1, F2,    16'd61});
        vecs.push_back('{8'd7,  16'd69,  1'b0, 1'b0, F1, 1'b0, 32'h0, 16'h0});
        vecs.push_back('{8'd7,  16'd70,  1'b1, 1'b1, F6, 1'b1, F6,    16'd70});
        vecs.push_back('{8'd9,  16'd90,  1'b1, 1'b0, F1, 1'b0, 32'h0, 16'h0});
        vecs.push_back('{8'd9,  16'd91,  1'b0, 1'b1, F3, 1'b1, F1,    16'd90});
        vecs.push_back('{8'd10, 16'd100, 1'b1, 1'b1, F3, 1'b1, F3,    16'd100});

        // Reset with a last hit for ray 6 presented: it must not be absorbed.
        rst = 1'b1;
        bus.list_to_ss_stall = 1'b0;
        drive_item(8'd6, 8'h00, 16'd66, 1'b1, 1'b1, F1);
        bus.int_to_list_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_out_valid", 64'(bus.list_to_ss_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.int_to_list_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid", 64'(bus.list_to_ss_valid), 64'd0);
        chk("post_rst_in_stall", 64'(bus.int_to_list_stall), 64'd0);
        @(posedge clk);
        #1;
        send(8'd6, 8'h01, 16'd67, 1'b0, 1'b1, F2, 1'b0, 32'h0, 16'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].ray, 8'(i + 16), vecs[i].tri_id, vecs[i].hit, vecs[i].last, vecs[i].t,
                 vecs[i].exp_hit, vecs[i].exp_t, vecs[i].exp_tri);
        end
        drain();

        // Backpressure: ray 1 result held while ray 2's last item waits upstream.
        bus.list_to_ss_stall = 1'b1;
        send(8'd2, 8'h40, 16'd41, 1'b1, 1'b0, F2, 1'b0, 32'h0, 16'h0);
        send(8'd1, 8'h41, 16'd30, 1'b1, 1'b1, F6, 1'b1, F6, 16'd30);
        fork
            send(8'd2, 8'h42, 16'd42, 1'b1, 1'b1, F3, 1'b1, F2, 16'd41);
            begin
                repeat (10) begin
                    @(negedge clk);
                    chk("bp_in_stall", 64'(bus.int_to_list_stall), 64'd1);
                    chk("bp_out_valid", 64'(bus.list_to_ss_valid), 64'd1);
                    chk("bp_hold_t", 64'(bus.list_to_ss_data.t_int), 64'(F6));
                    chk("bp_hold_tri", 64'(bus.list_to_ss_data.triID), 64'd30);
                end
                @(posedge clk);
                #1;
                bus.list_to_ss_stall = 1'b0;
                @(negedge clk);
                chk("bp_release_ray1", 64'(bus.list_to_ss_data.ray_info.rayID), 64'd1);
                @(posedge clk);
                #1;
                @(negedge clk);
                chk("bp_no_bubble_valid", 64'(bus.list_to_ss_valid), 64'd1);
                chk("bp_next_ray2", 64'(bus.list_to_ss_data.ray_info.rayID), 64'd2);
            end
        join
        drain();

        // Reset in the middle of ray 4 discards its earlier hit.
        send(8'd4, 8'h50, 16'd80, 1'b1, 1'b0, F1, 1'b0, 32'h0, 16'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(8'd4, 8'h51, 16'd81, 1'b1, 1'b1, F3, 1'b1, F3, 16'd81);
        drain();

        repeat (3) @(negedge clk);
        chk("idle_out_valid", 64'(bus.list_to_ss_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
